// File: rtl/seq_adder_sched.sv
// Round-robin scheduler sharing one multi-cycle adder among NREQ requesters.
// Optional watchdog on the adder result: define SEQ_ADDER_SCHED_WDOG_EN.
module seq_adder_sched #(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 2*DWIDTH+8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_in1,
  input  logic [NREQ*DWIDTH-1:0] req_in2,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]      rsp_sum,
  output logic                   rsp_carry,
  output logic                   rsp_err,
  output logic [DWIDTH-1:0]      add_in1,
  output logic [DWIDTH-1:0]      add_in2,
  output logic                   add_ivalid,
  input  logic [DWIDTH-1:0]      add_sum,
  input  logic                   add_carry,
  input  logic                   add_ovalid,
  input  logic                   add_busy
);

  // state | meaning
  // IDLE  | arbitrating, req_ready on the granted requester
  // ISSUE | operands latched, waiting for add_busy low to strobe the adder
  // WAIT  | job in flight, waiting for add_ovalid (or watchdog)
  // RESP  | one-cycle rsp_valid to the owner, pointer advances
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, owner, grant, idx;
  logic              grant_found, accept, wdog_hit;
  logic [DWIDTH-1:0] op1, op2;

  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

  assign accept = (state == IDLE) && grant_found;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (!add_busy) state_nxt = WAIT;
      WAIT:    if (add_ovalid || wdog_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    add_ivalid = 1'b0;
    case (state)
      IDLE:    if (grant_found) req_ready[grant] = 1'b1;
      ISSUE:   add_ivalid = !add_busy;
      RESP:    rsp_valid[owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op1   <= '0;
      op2   <= '0;
      owner <= '0;
    end else if (accept) begin
      op1   <= req_in1[grant*DWIDTH +: DWIDTH];
      op2   <= req_in2[grant*DWIDTH +: DWIDTH];
      owner <= grant;
    end
  end

  assign add_in1 = op1;
  assign add_in2 = op2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              ptr <= '0;
    else if (state == RESP) ptr <= (owner == PW'(NREQ-1)) ? '0 : owner + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end else if (state == WAIT && add_ovalid) begin
      rsp_sum   <= add_sum;
      rsp_carry <= add_carry;
    end else if (wdog_hit) begin
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end
  end

`ifdef SEQ_ADDER_SCHED_WDOG_EN
  localparam int WW = $clog2(TIMEOUT+1);
  logic [WW-1:0] wdog;

  // Held at zero outside WAIT, so it is clear on every entry to WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              wdog <= '0;
    else if (state == WAIT) wdog <= wdog + 1'b1;
    else                    wdog <= '0;
  end

  assign wdog_hit = (state == WAIT) && !add_ovalid && (wdog == WW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            rsp_err <= 1'b0;
    else if (state == WAIT && add_ovalid) rsp_err <= 1'b0;
    else if (wdog_hit)                    rsp_err <= 1'b1;
  end
`else
  // Watchdog compiled out: constant-false, WAIT waits for the adder forever.
  assign wdog_hit = (TIMEOUT < 0);
  assign rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_adder_sched.sv
// Directed bench for seq_adder_sched with a behavioural fixed-latency adder
// and a queue of expected responses.
module tb_seq_adder_sched;
  localparam int NREQ = 4, DW = 8, TIMEOUT = 2*DW+8, LAT = 3;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid = '0, req_ready, rsp_valid;
  logic [NREQ*DW-1:0] req_in1 = '0, req_in2 = '0;
  logic [DW-1:0]      rsp_sum, add_in1, add_in2;
  logic               rsp_carry, rsp_err, add_ivalid;
  logic [DW-1:0]      add_sum = '0;
  logic               add_carry = 1'b0, add_ovalid = 1'b0, add_busy = 1'b0;

  seq_adder_sched #(.NREQ(NREQ), .DWIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .add_in1(add_in1), .add_in2(add_in2), .add_ivalid(add_ivalid),
    .add_sum(add_sum), .add_carry(add_carry), .add_ovalid(add_ovalid), .add_busy(add_busy)
  );

  int errors = 0, checks = 0, n_issue = 0, n_rsp = 0, lat = 0;
  logic adder_dead = 1'b0;
  logic [DW:0] res = '0;

  // Adder model: result pulse LAT cycles after the load strobe.
  always @(posedge clk) begin
    add_ovalid <= 1'b0;
    if (!rstn) lat <= 0;
    else if (add_ivalid) begin
      lat     <= LAT;
      res     <= {1'b0, add_in1} + {1'b0, add_in2};
      n_issue <= n_issue + 1;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1 && !adder_dead) begin
        add_ovalid <= 1'b1;
        add_sum    <= res[DW-1:0];
        add_carry  <= res[DW];
      end
    end
  end

  always @(posedge clk) if (rsp_valid != '0) n_rsp <= n_rsp + 1;

  typedef struct { int owner; logic [DW-1:0] sum; logic carry; logic err; } sb_t;
  sb_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int owner, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic err);
    sb_t e;
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    e.owner = owner;
    e.sum   = err ? '0 : s[DW-1:0];
    e.carry = err ? 1'b0 : s[DW];
    e.err   = err;
    sb.push_back(e);
  endtask

  // Present one request, check the handshake and the adder strobe; returns
  // how many extra cycles the grant took.
  task automatic send(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input int busy_cycles, input logic err, output int waited);
    int n = 0;
    logic [NREQ-1:0] one;
    push(i, a, b, err);
    one = '0;
    one[i] = 1'b1;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_in1[i*DW +: DW] = a;
    req_in2[i*DW +: DW] = b;
    add_busy = (busy_cycles > 0);
    #1;
    while (!req_ready[i] && n < 20) begin @(negedge clk); #1; n++; end
    waited = n;
    chk("grant_onehot", 32'(req_ready), 32'(one));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < busy_cycles; k++) begin
      chk("busy_hold_ivalid", 32'(add_ivalid), 0);
      @(negedge clk);
    end
    add_busy = 1'b0;
    #1;
    chk("issue_ivalid", 32'(add_ivalid), 1);
    chk("issue_in1", 32'(add_in1), 32'(a));
    chk("issue_in2", 32'(add_in2), 32'(b));
    chk("issue_ready_low", 32'(req_ready), 0);
  endtask

  // Wait for the next response and compare it with the head of the queue.
  task automatic wait_rsp(input string tag, input int budget, output int cyc);
    sb_t e;
    logic [NREQ-1:0] ev;
    int n = 0;
    cyc = 0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    while (rsp_valid === '0 && n < budget) begin @(negedge clk); n++; end
    cyc = n;
    if (rsp_valid === '0) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    ev = '0;
    ev[e.owner] = 1'b1;
    chk({tag, "_owner"}, 32'(rsp_valid), 32'(ev));
    chk({tag, "_sum"}, 32'(rsp_sum), 32'(e.sum));
    chk({tag, "_carry"}, 32'(rsp_carry), 32'(e.carry));
    chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rsp_valid), 0);
    chk({tag, "_hold"}, 32'({rsp_err, rsp_carry, rsp_sum}), 32'({e.err, e.carry, e.sum}));
  endtask

  initial begin
    int cyc, waited, n0, i0;

    repeat (3) @(negedge clk);
    chk("reset_ctl", 32'({req_ready, rsp_valid, add_ivalid, rsp_carry, rsp_err}), 0);
    chk("reset_data", 32'({rsp_sum, add_in1, add_in2}), 0);
    @(posedge clk); #2 rstn = 1'b1;

    // All four valid: grants rotate 0,1,2,3,0.
    i0 = n_issue;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_in1[i*DW +: DW] = 8'(8'h10*i + 1);
      req_in2[i*DW +: DW] = 8'(i + 3);
    end
    req_valid = '1;
    for (int j = 0; j < 5; j++) push(j % NREQ, 8'(8'h10*(j%NREQ) + 1), 8'((j%NREQ) + 3), 1'b0);
    for (int j = 0; j < 5; j++) wait_rsp("rr", 40, cyc);
    req_valid = '0;
    chk("rr_issues", 32'(n_issue - i0), 5);

    // Single requester 0: 0F + 01.
    i0 = n_issue;
    send(0, 8'h0F, 8'h01, 0, 1'b0, waited);
    wait_rsp("req0", 40, cyc);
    chk("req0_latency", 32'(cyc), LAT + 2);
    chk("req0_issues", 32'(n_issue - i0), 1);

    // Carry out from requester 2.
    send(2, 8'hFF, 8'h01, 0, 1'b0, waited);
    wait_rsp("req2_carry", 40, cyc);

    // Same requester twice in a row is served each time.
    send(2, 8'h80, 8'h80, 0, 1'b0, waited);
    wait_rsp("req2_again", 40, cyc);

    // Adder busy for 5 cycles in ISSUE: strobe delayed and issued once.
    i0 = n_issue;
    send(1, 8'h3C, 8'h42, 5, 1'b0, waited);
    wait_rsp("busy", 40, cyc);
    chk("busy_issues", 32'(n_issue - i0), 1);

    // Reset during WAIT: job dropped, outputs cleared, next job completes.
    n0 = n_rsp;
    send(3, 8'h22, 8'h33, 0, 1'b0, waited);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midreset_ctl", 32'({req_ready, rsp_valid, add_ivalid, rsp_carry, rsp_err}), 0);
    chk("midreset_data", 32'({rsp_sum, add_in1, add_in2}), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("midreset_no_rsp", 32'(n_rsp - n0), 0);
    @(posedge clk); #2 rstn = 1'b0;
    @(posedge clk); #2 rstn = 1'b1;
    send(3, 8'h40, 8'h02, 0, 1'b0, waited);
    chk("first_edge_grant", 32'(waited), 0);
    wait_rsp("post_reset", 40, cyc);

`ifdef SEQ_ADDER_SCHED_WDOG_EN
    adder_dead = 1'b1;
    send(1, 8'h55, 8'h66, 0, 1'b1, waited);
    wait_rsp("wdog", 60, cyc);
    chk("wdog_cycles", 32'(cyc), TIMEOUT + 1);
    adder_dead = 1'b0;
    send(0, 8'h01, 8'h02, 0, 1'b0, waited);
    wait_rsp("after_wdog", 40, cyc);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
